// File: rtl/alu_decode_stage_if.sv
// Handshake bundle between fetch stream, decode stage and execute stage.
// The slave modport is the decode stage itself; master is its environment.
interface alu_decode_stage_if #(
  parameter int INSTR_W  = 8,
  parameter int OPCODE_W = 4,
  parameter int ALU_OP_W = 3
);
  logic [INSTR_W-1:0]          in_word;
  logic                        in_valid;
  logic                        in_ready;
  logic                        out_valid;
  logic                        out_ready;
  logic [ALU_OP_W-1:0]         out_alu_op;
  logic [INSTR_W-OPCODE_W-1:0] out_operand;
  logic [INSTR_W-1:0]          out_imm;
  logic                        out_use_imm;
  logic                        out_illegal;

  modport master (
    output in_word, in_valid, out_ready,
    input  in_ready, out_valid, out_alu_op, out_operand, out_imm, out_use_imm, out_illegal
  );

  modport slave (
    input  in_word, in_valid, out_ready,
    output in_ready, out_valid, out_alu_op, out_operand, out_imm, out_use_imm, out_illegal
  );
endinterface

// File: rtl/alu_decode_stage.sv
// Registered decode stage: turns opcode words (plus an immediate word for
// ADDI/SUBI) into ALU micro-ops behind valid/ready flow control.
module alu_decode_stage #(
  parameter int INSTR_W  = 8,
  parameter int OPCODE_W = 4,
  parameter int ALU_OP_W = 3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_flush,
  alu_decode_stage_if.slave   bus
);

  typedef enum logic {S_OP = 1'b0, S_IMM = 1'b1} state_t;

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic                use_imm;
    logic                illegal;
  } dec_t;

  function automatic dec_t decode_op(input logic [OPCODE_W-1:0] op);
    dec_t d;
    d.alu_op  = '0;
    d.use_imm = 1'b0;
    d.illegal = 1'b0;
    case (op)
      OPCODE_W'(4'h0): d.alu_op = ALU_OP_W'(3'b000);
      OPCODE_W'(4'h1): d.alu_op = ALU_OP_W'(3'b001);
      OPCODE_W'(4'h2): d.alu_op = ALU_OP_W'(3'b010);
      OPCODE_W'(4'h3): d.alu_op = ALU_OP_W'(3'b011);
      OPCODE_W'(4'h4): d.alu_op = ALU_OP_W'(3'b100);
      OPCODE_W'(4'h5): d.alu_op = ALU_OP_W'(3'b101);
      OPCODE_W'(4'h6): d.alu_op = ALU_OP_W'(3'b110);
      OPCODE_W'(4'h7): d.alu_op = ALU_OP_W'(3'b111);
      OPCODE_W'(4'h8): begin
        d.alu_op  = ALU_OP_W'(3'b000);
        d.use_imm = 1'b1;
      end
      OPCODE_W'(4'h9): begin
        d.alu_op  = ALU_OP_W'(3'b001);
        d.use_imm = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  state_t                      r_state;
  logic                        r_out_valid;
  logic [ALU_OP_W-1:0]         r_out_alu_op;
  logic [INSTR_W-OPCODE_W-1:0] r_out_operand;
  logic [INSTR_W-1:0]          r_out_imm;
  logic                        r_out_use_imm;
  logic                        r_out_illegal;
  logic [ALU_OP_W-1:0]         r_pend_alu_op;
  logic [INSTR_W-OPCODE_W-1:0] r_pend_operand;

  logic                        w_in_ready;
  logic                        w_in_fire;
  logic                        w_out_fire;
  logic [OPCODE_W-1:0]         w_opcode;
  logic [INSTR_W-OPCODE_W-1:0] w_operand;
  dec_t                        w_dec;

  // in_ready looks only at the output slot, never at the incoming word
  assign w_in_ready = !i_rst && !i_flush && (!r_out_valid || bus.out_ready);
  assign w_in_fire  = bus.in_valid && w_in_ready;
  assign w_out_fire = r_out_valid && bus.out_ready;
  assign w_opcode   = bus.in_word[INSTR_W-1 -: OPCODE_W];
  assign w_operand  = bus.in_word[INSTR_W-OPCODE_W-1:0];
  assign w_dec      = decode_op(w_opcode);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_OP;
      r_out_valid    <= 1'b0;
      r_out_alu_op   <= '0;
      r_out_operand  <= '0;
      r_out_imm      <= '0;
      r_out_use_imm  <= 1'b0;
      r_out_illegal  <= 1'b0;
      r_pend_alu_op  <= '0;
      r_pend_operand <= '0;
    end else if (i_flush) begin
      r_state        <= S_OP;
      r_out_valid    <= 1'b0;
      r_pend_alu_op  <= '0;
      r_pend_operand <= '0;
    end else begin
      if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
      // a load in the same cycle as a drain overrides the clear above
      if (w_in_fire) begin
        case (r_state)
          S_OP: begin
            if (w_dec.use_imm) begin
              r_pend_alu_op  <= w_dec.alu_op;
              r_pend_operand <= w_operand;
              r_state        <= S_IMM;
            end else begin
              r_out_valid   <= 1'b1;
              r_out_alu_op  <= w_dec.alu_op;
              r_out_operand <= w_operand;
              r_out_imm     <= '0;
              r_out_use_imm <= 1'b0;
              r_out_illegal <= w_dec.illegal;
            end
          end
          S_IMM: begin
            r_out_valid   <= 1'b1;
            r_out_alu_op  <= r_pend_alu_op;
            r_out_operand <= r_pend_operand;
            r_out_imm     <= bus.in_word;
            r_out_use_imm <= 1'b1;
            r_out_illegal <= 1'b0;
            r_state       <= S_OP;
          end
          default: r_state <= S_OP;
        endcase
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_alu_op  = r_out_alu_op;
  assign bus.out_operand = r_out_operand;
  assign bus.out_imm     = r_out_imm;
  assign bus.out_use_imm = r_out_use_imm;
  assign bus.out_illegal = r_out_illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: default 8-bit build plus a 16-bit build.
module tb_alu_decode_stage;

  logic clk;
  logic rst;
  logic flush;
  int   n_tests;
  int   n_fail;

  alu_decode_stage_if #(.INSTR_W(8),  .OPCODE_W(4), .ALU_OP_W(3)) b8 ();
  alu_decode_stage_if #(.INSTR_W(16), .OPCODE_W(4), .ALU_OP_W(3)) b16 ();

  alu_decode_stage #(.INSTR_W(8), .OPCODE_W(4), .ALU_OP_W(3)) u_dut8 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (flush),
    .bus     (b8.slave)
  );

  alu_decode_stage #(.INSTR_W(16), .OPCODE_W(4), .ALU_OP_W(3)) u_dut16 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (flush),
    .bus     (b16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // checks the full 8-bit micro-op against expected fields
  task automatic check_uop8(input string tag, input logic v, input logic [2:0] op,
                            input logic [3:0] opnd, input logic [7:0] imm,
                            input logic ui, input logic ill);
    check_value({tag, ".valid"},   32'(b8.out_valid),   32'(v));
    check_value({tag, ".alu_op"},  32'(b8.out_alu_op),  32'(op));
    check_value({tag, ".operand"}, 32'(b8.out_operand), 32'(opnd));
    check_value({tag, ".imm"},     32'(b8.out_imm),     32'(imm));
    check_value({tag, ".use_imm"}, 32'(b8.out_use_imm), 32'(ui));
    check_value({tag, ".illegal"}, 32'(b8.out_illegal), 32'(ill));
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    flush         = 1'b0;
    b8.in_valid   = 1'b1;
    b8.in_word    = 8'h2B;
    b8.out_ready  = 1'b1;
    b16.in_valid  = 1'b0;
    b16.in_word   = 16'h0000;
    b16.out_ready = 1'b1;

    // reset held two cycles with input offered
    step();
    step();
    check_value("rst.in_ready", 32'(b8.in_ready), 32'd0);
    check_uop8("rst", 1'b0, 3'd0, 4'h0, 8'h00, 1'b0, 1'b0);
    rst         = 1'b0;
    b8.in_valid = 1'b0;
    #1;
    check_value("rst_rel.in_ready", 32'(b8.in_ready), 32'd1);

    // back-to-back single-word stream
    b8.in_valid = 1'b1;
    b8.in_word  = 8'h2B;
    step();
    check_uop8("b2b0", 1'b1, 3'b010, 4'hB, 8'h00, 1'b0, 1'b0);
    b8.in_word = 8'h71;
    step();
    check_uop8("b2b1", 1'b1, 3'b111, 4'h1, 8'h00, 1'b0, 1'b0);
    b8.in_word = 8'hF3;
    step();
    check_uop8("b2b2", 1'b1, 3'b000, 4'h3, 8'h00, 1'b0, 1'b1);
    b8.in_valid = 1'b0;
    step();
    check_value("b2b_drain.valid", 32'(b8.out_valid), 32'd0);

    // ADDI with a two-cycle gap before the immediate
    b8.in_valid = 1'b1;
    b8.in_word  = 8'h86;
    step();
    check_value("imm_op.valid", 32'(b8.out_valid), 32'd0);
    b8.in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check_value("imm_gap.valid", 32'(b8.out_valid), 32'd0);
    end
    b8.in_valid = 1'b1;
    b8.in_word  = 8'h5A;
    step();
    check_uop8("imm", 1'b1, 3'b000, 4'h6, 8'h5A, 1'b1, 1'b0);
    b8.in_valid = 1'b0;
    step();
    check_value("imm_once.valid", 32'(b8.out_valid), 32'd0);

    // backpressure, then drain and reload in one cycle
    b8.out_ready = 1'b0;
    b8.in_valid  = 1'b1;
    b8.in_word   = 8'h35;
    step();
    check_uop8("bp_load", 1'b1, 3'b011, 4'h5, 8'h00, 1'b0, 1'b0);
    b8.in_word = 8'h12;
    #1;
    check_value("bp.in_ready", 32'(b8.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_uop8("bp_hold", 1'b1, 3'b011, 4'h5, 8'h00, 1'b0, 1'b0);
      check_value("bp_hold.in_ready", 32'(b8.in_ready), 32'd0);
    end
    b8.out_ready = 1'b1;
    #1;
    check_value("bp_rel.in_ready", 32'(b8.in_ready), 32'd1);
    step();
    check_uop8("bp_reload", 1'b1, 3'b001, 4'h2, 8'h00, 1'b0, 1'b0);
    b8.in_valid = 1'b0;
    step();
    check_value("bp_drain.valid", 32'(b8.out_valid), 32'd0);

    // flush in the middle of SUBI discards the partial instruction
    b8.in_valid = 1'b1;
    b8.in_word  = 8'h94;
    step();
    check_value("fl_op.valid", 32'(b8.out_valid), 32'd0);
    b8.in_valid = 1'b0;
    flush       = 1'b1;
    #1;
    check_value("fl.in_ready", 32'(b8.in_ready), 32'd0);
    step();
    flush = 1'b0;
    check_value("fl_after.valid", 32'(b8.out_valid), 32'd0);
    b8.in_valid = 1'b1;
    b8.in_word  = 8'h40;
    step();
    check_uop8("fl_next", 1'b1, 3'b100, 4'h0, 8'h00, 1'b0, 1'b0);
    b8.in_valid = 1'b0;
    step();

    // flush drops an undrained micro-op
    b8.out_ready = 1'b0;
    b8.in_valid  = 1'b1;
    b8.in_word   = 8'h1C;
    step();
    check_uop8("fl_drop_load", 1'b1, 3'b001, 4'hC, 8'h00, 1'b0, 1'b0);
    b8.in_valid = 1'b0;
    flush       = 1'b1;
    step();
    flush = 1'b0;
    check_value("fl_drop.valid", 32'(b8.out_valid), 32'd0);
    b8.out_ready = 1'b1;

    // 16-bit build: SUBI with a 16-bit immediate
    b16.in_valid = 1'b1;
    b16.in_word  = 16'h9ABC;
    step();
    check_value("w16_op.valid", 32'(b16.out_valid), 32'd0);
    b16.in_word = 16'h1234;
    step();
    check_value("w16.valid",   32'(b16.out_valid),   32'd1);
    check_value("w16.alu_op",  32'(b16.out_alu_op),  32'd1);
    check_value("w16.operand", 32'(b16.out_operand), 32'h0ABC);
    check_value("w16.imm",     32'(b16.out_imm),     32'h1234);
    check_value("w16.use_imm", 32'(b16.out_use_imm), 32'd1);
    check_value("w16.illegal", 32'(b16.out_illegal), 32'd0);
    b16.in_valid = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
